// File: rtl/square_cell.sv
// square_cell: LU systolic inner cell, captures u then emits x - l*u per element; SQUARE_CELL_SAT_EN selects saturation over wrap.
module square_cell #(
  parameter int SZ = 8,
  parameter int FRAC = 4,
  parameter int N = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid_in,
  input  logic [SZ-1:0] x,
  input  logic [SZ-1:0] xInv,
  output logic [SZ-1:0] xOut,
  output logic          xOutValid,
  output logic [SZ-1:0] xInvOut,
  output logic          xInvValid,
  output logic [SZ-1:0] uOut,
  output logic          uValid
);
  localparam int CW = $clog2(N);
  typedef enum logic {CAPTURE, UPDATE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [SZ-1:0] u;
  logic signed [2*SZ-1:0] prod, scaled;
  logic signed [2*SZ:0] diff;
  logic [SZ-1:0] res;
  logic last;
  assign prod = $signed(xInv) * $signed(u);
  assign scaled = prod >>> FRAC;
  assign diff = {{(SZ+1){x[SZ-1]}}, x} - {scaled[2*SZ-1], scaled};
  assign last = cnt == CW'(N-1);
`ifdef SQUARE_CELL_SAT_EN
  // in range only when every bit above the result sign matches it
  assign res = (&diff[2*SZ:SZ-1] | ~|diff[2*SZ:SZ-1]) ? diff[SZ-1:0]
             : {diff[2*SZ], {(SZ-1){~diff[2*SZ]}}};
`else
  logic unused_hi;
  assign unused_hi = ^diff[2*SZ:SZ];
  assign res = diff[SZ-1:0];
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CAPTURE;
      cnt <= '0;
      u <= '0;
      xOut <= '0;
      xOutValid <= 1'b0;
      xInvOut <= '0;
      xInvValid <= 1'b0;
      uOut <= '0;
      uValid <= 1'b0;
    end else begin
      xOutValid <= 1'b0;
      uValid <= 1'b0;
      xInvValid <= valid_in;
      if (valid_in) begin
        xInvOut <= xInv;
        if (state == CAPTURE) begin
          u <= x;
          uOut <= x;
          uValid <= 1'b1;
          cnt <= CW'(1);
          state <= UPDATE;
        end else begin
          xOut <= res;
          xOutValid <= 1'b1;
          cnt <= last ? '0 : cnt + CW'(1);
          state <= last ? CAPTURE : UPDATE;
        end
      end
    end
  end
endmodule

// File: tb/tb_square_cell.sv
// tb_square_cell: directed scoreboard bench for square_cell (SZ=8, FRAC=4, N=4).
module tb_square_cell;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic valid_in = 1'b0;
  logic [7:0] x = '0, xInv = '0;
  logic [7:0] xOut, xInvOut, uOut;
  logic xOutValid, xInvValid, uValid;
  int checks = 0, failures = 0;

  typedef struct {logic [7:0] xo, xio, uo; logic xov, xiv, uv;} exp_t;
  exp_t sb[$];
  exp_t m;
  logic m_upd = 1'b0;
  int m_cnt = 0;
  logic [7:0] m_u = '0;

  square_cell #(.SZ(8), .FRAC(4), .N(4)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .x(x), .xInv(xInv),
    .xOut(xOut), .xOutValid(xOutValid), .xInvOut(xInvOut), .xInvValid(xInvValid),
    .uOut(uOut), .uValid(uValid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_update(input logic [7:0] xv, input logic [7:0] li, input logic [7:0] uu);
    int a, b, c, d;
    a = $signed(xv);
    b = $signed(li);
    c = $signed(uu);
    d = a - ((b * c) >>> 4);
`ifdef SQUARE_CELL_SAT_EN
    if (d > 127) d = 127;
    if (d < -128) d = -128;
`endif
    return d[7:0];
  endfunction

  task automatic drive(input logic r, input logic v, input logic [7:0] xv, input logic [7:0] li);
    exp_t e;
    rst = r;
    valid_in = v;
    x = xv;
    xInv = li;
    m.xov = 1'b0;
    m.uv = 1'b0;
    m.xiv = v;
    if (r) begin
      m = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
      m_upd = 1'b0;
      m_cnt = 0;
      m_u = '0;
    end else if (v) begin
      m.xio = li;
      if (!m_upd) begin
        m_u = xv;
        m.uo = xv;
        m.uv = 1'b1;
        m_cnt = 1;
        m_upd = 1'b1;
      end else begin
        m.xo = model_update(xv, li, m_u);
        m.xov = 1'b1;
        if (m_cnt == 3) begin
          m_cnt = 0;
          m_upd = 1'b0;
        end else m_cnt++;
      end
    end
    sb.push_back(m);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("xOut", xOut, e.xo);
    chk("xOutValid", {7'd0, xOutValid}, {7'd0, e.xov});
    chk("xInvOut", xInvOut, e.xio);
    chk("xInvValid", {7'd0, xInvValid}, {7'd0, e.xiv});
    chk("uOut", uOut, e.uo);
    chk("uValid", {7'd0, uValid}, {7'd0, e.uv});
  endtask

  initial begin
    m = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
    @(posedge clk);
    #1;
    drive(1, 1, 8'h55, 8'h11);
    drive(1, 1, 8'h55, 8'h11);
    chk("reset_xOut", xOut, 8'h00);
    chk("reset_uValid", {7'd0, uValid}, 8'h00);
    drive(0, 1, 8'h20, 8'h33);
    chk("basic_capture_uValid", {7'd0, uValid}, 8'h01);
    chk("basic_capture_uOut", uOut, 8'h20);
    chk("basic_capture_noXOutValid", {7'd0, xOutValid}, 8'h00);
    drive(0, 1, 8'h30, 8'h18);
    chk("basic_upd1", xOut, 8'h00);
    drive(0, 1, 8'h10, 8'h10);
    chk("basic_upd2", xOut, 8'hF0);
    chk("basic_xInvOut", xInvOut, 8'h10);
    drive(0, 1, 8'h00, 8'h00);
    chk("basic_upd3", xOut, 8'h00);
    chk("basic_upd3_valid", {7'd0, xOutValid}, 8'h01);
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 8'($urandom_range(255)), 8'($urandom_range(255)));
      chk("wrap_uValid", {7'd0, uValid}, (i == 0 || i == 4) ? 8'h01 : 8'h00);
    end
    drive(0, 1, 8'h18, 8'h00);
    drive(0, 1, 8'h40, 8'h08);
    chk("gap_pre", xOut, 8'h34);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 8'($urandom_range(255)), 8'($urandom_range(255)));
      chk("gap_hold_xOut", xOut, 8'h34);
    end
    drive(0, 1, 8'h00, 8'hF0);
    chk("gap_resume", xOut, 8'h18);
    drive(0, 1, 8'h05, 8'h00);
    drive(0, 1, 8'h7F, 8'h00);
    chk("ovf_capture_uValid", {7'd0, uValid}, 8'h01);
    drive(0, 1, 8'h80, 8'h7F);
`ifdef SQUARE_CELL_SAT_EN
    chk("ovf", xOut, 8'h80);
`else
    chk("ovf", xOut, 8'h90);
`endif
    drive(0, 1, 8'h10, 8'h10);
    drive(1, 1, 8'h22, 8'h10);
    drive(0, 1, 8'h44, 8'h10);
    chk("midreset_capture", {7'd0, uValid}, 8'h01);
    chk("midreset_uOut", uOut, 8'h44);
    drive(0, 0, 8'h00, 8'h00);
    chk("sb_empty", 8'(sb.size()), 8'h00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/square_cell.md
# square_cell

Internal (square) processing element of the LU-factorization systolic array: the downstream consumer of the boundary cell's multiplier stream. It latches one row element u of the current elimination step, then updates every following element of its column as x − l·u, where l is the multiplier arriving from the left. It forwards l to the right and the updated value downward.

## Interface
- SZ, 8: data width, two's-complement signed fixed point
- FRAC, 4: fractional bits of the multiplier input (Q(SZ−FRAC).FRAC)
- N, 4: matrix order; elements per elimination step, including the captured one; N ≥ 2
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- valid_in  in  1  x and xInv are valid this cycle
- x  in  SZ  matrix element arriving from above
- xInv  in  SZ  multiplier l arriving from the left (boundary cell or previous square cell)
- xOut  out  SZ  updated element, passed down
- xOutValid  out  1  xOut is valid
- xInvOut  out  SZ  registered copy of xInv, passed right
- xInvValid  out  1  xInvOut is valid
- uOut  out  SZ  captured row element (U-matrix readout)
- uValid  out  1  one-cycle pulse when uOut is updated

## Operation
- Two states: CAPTURE and UPDATE. Element counter cnt has width $clog2(N).
- CAPTURE, valid_in=1:
  - u ← x; uOut ← x; uValid pulses.
  - cnt ← 1; state ← UPDATE.
  - xOutValid stays 0. The captured element does not propagate down.
- UPDATE, valid_in=1:
  - prod = signed(xInv) × signed(u), 2·SZ bits.
  - scaled = prod >>> FRAC (arithmetic shift).
  - diff = sign-extended x − scaled, computed at 2·SZ+1 bits.
  - xOut ← diff reduced to SZ bits (see Configuration); xOutValid ← 1.
  - If cnt = N−1: cnt ← 0, state ← CAPTURE. Otherwise cnt ← cnt+1.
- Any state, valid_in=1: xInvOut ← xInv; xInvValid ← 1.
- valid_in=0:
  - State, cnt and u hold.
  - xOutValid, xInvValid and uValid drop to 0.
  - Data outputs hold their last values.
- u is used only after it is captured. The first UPDATE cycle uses the u latched in the preceding CAPTURE.

## Timing
- Reset values: xOut, xInvOut and uOut are 0; xOutValid, xInvValid and uValid are 0; state is CAPTURE; cnt is 0; u is 0.
- All outputs are registered, with 1-cycle latency from valid_in.
- Throughput is one element per cycle. Back-to-back steps need no idle cycle: the sample after cnt=N−1 is captured as the new u.
- rst has priority over valid_in in the same cycle. Reset mid-step abandons the step; the next valid sample is treated as a capture.
- There is no backpressure. The upstream side must not present valid_in while the array is stalled.

## Configuration
- SQUARE_CELL_SAT_EN defined:
  - diff saturates to the range [−2^(SZ−1), 2^(SZ−1)−1].
  - For SZ=8, overflow gives 0x7F and underflow gives 0x80.
- SQUARE_CELL_SAT_EN undefined:
  - diff is truncated to its low SZ bits (two's-complement wrap).
  - No saturation logic is instantiated.

## Test plan
All scenarios use SZ=8, FRAC=4, N=4.
- Reset:
  - Stimulus: hold rst for 2 cycles with valid_in=1.
  - Required: all outputs 0, no valid pulses; the first valid sample after release is captured (uValid=1).
- Basic step:
  - Stimulus: capture x=0x20 (u=2.0). Then (x=0x30, xInv=0x18) gives xOut=0x00. Then (x=0x10, xInv=0x10) gives xOut=0xF0. Then (x=0x00, xInv=0x00) gives xOut=0x00.
  - Required: xOutValid on exactly the 3 update cycles; xInvOut echoes xInv each cycle.
- Wrap to next step:
  - Stimulus: 8 consecutive valid samples.
  - Required: samples 1 and 5 are captured (uValid pulses, uOut=x); samples 2–4 and 6–8 produce xOut.
- Gaps:
  - Stimulus: deassert valid_in for 3 cycles in the middle of a step.
  - Required: valids drop, cnt and u hold, and the step resumes correctly.
- Overflow:
  - Stimulus: capture u=0x7F, then x=0x80 with xInv=0x7F.
  - Required: with SQUARE_CELL_SAT_EN, xOut=0x80; without it, xOut=0x90.
- Mid-step reset:
  - Stimulus: assert rst after 2 updates.
  - Required: the next valid sample is captured, not updated.
